// File: rtl/spart_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package : spart_pkg                                                  |
// | Purpose : Shared types and constants for the SPART receive path:     |
// |           receiver state enum, default oversampling factor and the   |
// |           driver-visible register address codes.                     |
// | Ports   : none (package)                                             |
// | Config  : SPART_RX_PARITY_EN (consumed by spart_rx_core)             |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
package spart_pkg;

  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
    RX_PARITY = 3'd3,
    RX_STOP   = 3'd4,
    RX_BREAK  = 3'd5
  } rx_state_t;

  localparam int DEFAULT_OVERSAMPLE = 16;

  // Driver register map (ioaddr)
  localparam logic [1:0] ADDR_BUF    = 2'b00;
  localparam logic [1:0] ADDR_STATUS = 2'b01;
  localparam logic [1:0] ADDR_DIV_LO = 2'b10;
  localparam logic [1:0] ADDR_DIV_HI = 2'b11;

endpackage : spart_pkg
`default_nettype wire

// File: rtl/spart_sync.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : spart_sync                                                 |
// | Purpose : Two-flop synchronizer for the asynchronous serial line.    |
// |           Both flops reset to 1 so an idle-high line never looks     |
// |           like a start bit coming out of reset.                      |
// | Ports   : clk  - system clock                                        |
// |           rst  - synchronous active-low reset                        |
// |           d    - asynchronous input                                  |
// |           q    - synchronized output                                 |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module spart_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (!rst) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule : spart_sync
`default_nettype wire

// File: rtl/spart_rx_core.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : spart_rx_core                                              |
// | Purpose : Oversampling UART receiver. Detects the start bit, samples |
// |           each bit at its centre, assembles the byte LSB first and   |
// |           presents it with data-available and error flags.           |
// | Ports   : clk      - system clock                                    |
// |           rst      - synchronous active-low reset                    |
// |           rxd      - asynchronous serial line, idle high             |
// |           baud_en  - OVERSAMPLE-x bit-rate tick                      |
// |           rd_ack   - driver read of the receive buffer               |
// |           rx_data  - last received byte                              |
// |           rda      - receive data available                          |
// |           frm_err  - stop bit of rx_data byte sampled low            |
// |           ovr_err  - byte completed while rda already set            |
// |           par_err  - even-parity mismatch on rx_data byte            |
// | Config  : SPART_RX_PARITY_EN - adds an even-parity bit after bit 7   |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module spart_rx_core
  import spart_pkg::*;
#(
  parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  input  logic       baud_en,
  input  logic       rd_ack,
  output logic [7:0] rx_data,
  output logic       rda,
  output logic       frm_err,
  output logic       ovr_err,
  output logic       par_err
);

  localparam int            TW        = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  // Last tick of the half-bit wait: the start bit is checked at its centre
  localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);

  logic          rxd_s;
  rx_state_t     state, state_n;
  logic [TW-1:0] tick, tick_n;
  logic [2:0]    bit_cnt, bit_cnt_n;
  logic [7:0]    shreg, shreg_n;
  logic          load;

  spart_sync u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rxd),
    .q   (rxd_s)
  );

`ifdef SPART_RX_PARITY_EN
  logic par_bit, par_bit_n;
`endif

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= RX_IDLE;
      tick    <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
`ifdef SPART_RX_PARITY_EN
      par_bit <= 1'b0;
`endif
    end else begin
      state   <= state_n;
      tick    <= tick_n;
      bit_cnt <= bit_cnt_n;
      shreg   <= shreg_n;
`ifdef SPART_RX_PARITY_EN
      par_bit <= par_bit_n;
`endif
    end
  end

  // Next-state logic; counters only move on baud_en
  always_comb begin
    state_n   = state;
    tick_n    = tick;
    bit_cnt_n = bit_cnt;
    shreg_n   = shreg;
    load      = 1'b0;
`ifdef SPART_RX_PARITY_EN
    par_bit_n = par_bit;
`endif
    case (state)
      RX_IDLE: begin
        if (baud_en && !rxd_s) begin
          state_n = RX_START;
          tick_n  = '0;
        end
      end
      RX_START: begin
        if (baud_en) begin
          if (tick == TICK_MID) begin
            tick_n    = '0;
            bit_cnt_n = '0;
            // A line back high at mid-start was a glitch, not a frame
            state_n   = rxd_s ? RX_IDLE : RX_DATA;
          end else begin
            tick_n = tick + TW'(1);
          end
        end
      end
      RX_DATA: begin
        if (baud_en) begin
          if (tick == TICK_LAST) begin
            tick_n    = '0;
            shreg_n   = {rxd_s, shreg[7:1]};
            bit_cnt_n = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
`ifdef SPART_RX_PARITY_EN
              state_n = RX_PARITY;
`else
              state_n = RX_STOP;
`endif
            end
          end else begin
            tick_n = tick + TW'(1);
          end
        end
      end
      RX_PARITY: begin
`ifdef SPART_RX_PARITY_EN
        if (baud_en) begin
          if (tick == TICK_LAST) begin
            tick_n    = '0;
            par_bit_n = rxd_s;
            state_n   = RX_STOP;
          end else begin
            tick_n = tick + TW'(1);
          end
        end
`else
        state_n = RX_IDLE;
`endif
      end
      RX_STOP: begin
        if (baud_en) begin
          if (tick == TICK_LAST) begin
            tick_n  = '0;
            load    = 1'b1;
            // A low stop bit usually means a break; wait for the line to recover
            state_n = rxd_s ? RX_IDLE : RX_BREAK;
          end else begin
            tick_n = tick + TW'(1);
          end
        end
      end
      RX_BREAK: begin
        if (rxd_s) begin
          state_n = RX_IDLE;
        end
      end
      default: begin
        state_n = RX_IDLE;
      end
    endcase
  end

  // Host-visible buffer and flags. A completion in the same cycle as
  // rd_ack wins: the new byte is reported but not counted as an overrun.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_data <= 8'h00;
      rda     <= 1'b0;
      frm_err <= 1'b0;
      ovr_err <= 1'b0;
`ifdef SPART_RX_PARITY_EN
      par_err <= 1'b0;
`endif
    end else if (load) begin
      rx_data <= shreg;
      rda     <= 1'b1;
      frm_err <= ~rxd_s;
      ovr_err <= rda & ~rd_ack;
`ifdef SPART_RX_PARITY_EN
      par_err <= ^{shreg, par_bit};
`endif
    end else if (rd_ack) begin
      rda     <= 1'b0;
      ovr_err <= 1'b0;
    end
  end

`ifndef SPART_RX_PARITY_EN
  assign par_err = 1'b0;
`endif

endmodule : spart_rx_core
`default_nettype wire

// File: doc/spart_rx_core.md
SPART_RX_CORE -- requirements
Module: spart_rx_core

Interface
REQ-001 The block SHALL expose parameter OVERSAMPLE, default 16, meaning baud_en ticks per serial bit (even, 8..32).
REQ-002 The block SHALL have port clk  input  1  system clock; all state changes on the rising edge.
REQ-003 The block SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-004 The block SHALL have port rxd  input  1  asynchronous serial line, idle high.
REQ-005 The block SHALL have port baud_en  input  1  single-cycle OVERSAMPLE-x bit-rate tick from the baud generator.
REQ-006 The block SHALL have port rd_ack  input  1  one-cycle pulse when the driver reads the receive buffer (iocs & iorw & ioaddr==2'b00).
REQ-007 The block SHALL have port rx_data  output  8  last received byte.
REQ-008 The block SHALL have port rda  output  1  receive data available.
REQ-009 The block SHALL have port frm_err  output  1  stop bit of the byte in rx_data sampled low.
REQ-010 The block SHALL have port ovr_err  output  1  byte completed while rda was already set.
REQ-011 The block SHALL have port par_err  output  1  parity mismatch on the byte in rx_data.

Function
REQ-012 rxd SHALL pass through a 2-flop synchronizer; all sampling SHALL use the synchronized value.
REQ-013 The FSM states SHALL be IDLE, START, DATA, PARITY, STOP, BREAK; the tick counter and bit counter SHALL advance only on baud_en.
REQ-014 IDLE: synchronized rxd==0 on a baud_en cycle -> START, tick counter cleared.
REQ-015 START: at tick OVERSAMPLE/2 (mid-bit), rxd==0 -> DATA; rxd==1 -> IDLE (false start, no flags changed).
REQ-016 DATA: the block SHALL sample every OVERSAMPLE ticks, shifting LSB first; after bit 7 -> PARITY if enabled, else STOP.
REQ-017 STOP: one OVERSAMPLE later, sample stop bit, load rx_data, set rda, update frm_err/par_err; stop==1 -> IDLE, stop==0 -> BREAK.
REQ-018 BREAK: the FSM SHALL stay until synchronized rxd==1, then -> IDLE (no restart on a held-low line).
REQ-019 rda, rx_data, frm_err, par_err SHALL update in the clock cycle following the stop-bit-sampling baud_en cycle.
REQ-020 rd_ack SHALL clear rda and ovr_err on the next edge; rx_data SHALL hold its value.
REQ-021 A byte completing while rda==1 and rd_ack==0 SHALL overwrite rx_data and set ovr_err.
REQ-022 A byte completing in the same cycle as rd_ack SHALL leave rda=1, ovr_err=0 (set wins, no overrun).
REQ-023 rd_ack while rda==0 SHALL have no effect.

Reset
REQ-024 rst==0 at a clock edge SHALL force IDLE, counters 0, synchronizer flops 1, rx_data 8'h00, rda/frm_err/ovr_err/par_err 0, including mid-frame; the partial byte SHALL be discarded.

Configuration
REQ-025 With SPART_RX_PARITY_EN defined, the frame SHALL include an even-parity bit after bit 7, sampled in PARITY; par_err = mismatch.
REQ-026 Without SPART_RX_PARITY_EN, PARITY SHALL be unreachable, DATA -> STOP directly, and par_err SHALL be tied 0.

Structure
REQ-027 Package spart_pkg SHALL hold the rx state enum, default OVERSAMPLE, and the ioaddr codes (2'b00 buffer, 2'b01 status, 2'b10/2'b11 divisor low/high).
REQ-028 The synchronizer SHALL be sub-module spart_sync (2-flop, reset-to-1); all other logic is in spart_rx_core.

Verification (baud_en tied 1, OVERSAMPLE=16, bit = 16 clk, parity off unless noted)
REQ-029 Frame 8'hA5, stop=1 -> rda=1, rx_data=8'hA5, frm_err=0 one cycle after stop sample; rd_ack -> rda=0.
REQ-030 Back-to-back 8'hE7 then 8'h24, no rd_ack -> rx_data=8'h24, ovr_err=1; rd_ack clears both flags; rd_ack coincident with 2nd completion -> ovr_err=0.
REQ-031 rxd low for 4 clk then high -> FSM returns to IDLE, rda stays 0; following 8'h3C received correctly.
REQ-032 8'h81 with stop=0, line held low 40 clk -> rda=1, frm_err=1, FSM in BREAK until rxd high; next 8'h55 received with frm_err=0.
REQ-033 rst=0 pulsed mid-DATA of 8'hA5 -> all outputs 0 next edge; following 8'h5A received cleanly.
REQ-034 SPART_RX_PARITY_EN defined: 8'h07 with parity bit 1 -> par_err=0; parity bit 0 -> par_err=1, rx_data=8'h07.
